// File: rtl/scsi_bus_arbiter_pkg.sv
// Shared state encodings, default parameters and request qualification for the SCSI bus arbiter.
package scsi_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_GNT = 2'd1,
    ST_DMA_GNT = 2'd2,
    ST_TURN    = 2'd3
  } arb_state_e;

  localparam int unsigned DEF_TIMEOUT   = 64;
  localparam int unsigned DEF_MAX_BURST = 4;
  localparam int unsigned BURST_W       = 3;

  // DMA may only run when the FIFO can source or sink a transfer in the current direction
  function automatic logic dma_ok_f(input logic req, input logic en, input logic dir,
                                    input logic full, input logic empty);
    return req & en & (dir ? ~empty : ~full);
  endfunction

endpackage

// File: rtl/scsi_arb_wdog.sv
// Grant watchdog: counts clocks while enabled, flags the last allowed clock of a grant.
module scsi_arb_wdog
  import scsi_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic nCLK,
  input  logic CRESET_,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge nCLK or negedge CRESET_) begin
    if (!CRESET_)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + CW'(1);
  end

  assign expire_c = en & (cnt == LAST);

endmodule

// File: rtl/scsi_bus_arbiter.sv
// Arbitrates the SCSI controller bus between CPU PIO and DMA cycles with turnaround and watchdog.
// Optional DMA burst limiting over a pending CPU request is enabled by defining BURST_LIMIT_EN.
module scsi_bus_arbiter
  import scsi_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
`ifdef BURST_LIMIT_EN
  , parameter int unsigned MAX_BURST = DEF_MAX_BURST
`endif
) (
  input  logic nCLK,
  input  logic CRESET_,
  input  logic CPUREQ,
  input  logic DMAREQ,
  input  logic DMAEN,
  input  logic DMADIR,
  input  logic FIFOFULL,
  input  logic FIFOEMPTY,
  input  logic CYCLE_DONE,
  output logic GNT_CPU,
  output logic GNT_DMA,
  output logic ARB_BUSY,
  output logic ARB_TIMEOUT
);

  arb_state_e state, state_d;
  logic dma_ok_c;
  logic in_grant_c;
  logic expire_c;
  logic cpu_wins_c;
  logic timeout_d;

  assign dma_ok_c   = dma_ok_f(DMAREQ, DMAEN, DMADIR, FIFOFULL, FIFOEMPTY);
  assign in_grant_c = (state == ST_CPU_GNT) || (state == ST_DMA_GNT);

  // Counter sits at zero outside a grant, so every grant starts from a cleared count
  scsi_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .nCLK     (nCLK),
    .CRESET_  (CRESET_),
    .clr      (!in_grant_c),
    .en       (in_grant_c),
    .expire_c (expire_c)
  );

`ifdef BURST_LIMIT_EN
  logic [BURST_W-1:0] burst_q, burst_d;

  // DMA keeps the bus over a waiting CPU until MAX_BURST consecutive DMA grants
  assign cpu_wins_c = CPUREQ & ~(dma_ok_c & (burst_q < BURST_W'(MAX_BURST)));

  always_comb begin
    burst_d = burst_q;
    if ((state_d == ST_CPU_GNT) || (state_d == ST_IDLE))
      burst_d = '0;
    else if ((state_d == ST_DMA_GNT) && (state != ST_DMA_GNT) &&
             (burst_q < BURST_W'(MAX_BURST)))
      burst_d = burst_q + BURST_W'(1);
  end

  always_ff @(posedge nCLK or negedge CRESET_) begin
    if (!CRESET_) burst_q <= '0;
    else          burst_q <= burst_d;
  end
`else
  assign cpu_wins_c = CPUREQ;
`endif

  // Next-state logic; a grant ends only on CYCLE_DONE or watchdog expiry
  always_comb begin
    state_d   = state;
    timeout_d = 1'b0;
    case (state)
      ST_IDLE, ST_TURN: begin
        if (cpu_wins_c)    state_d = ST_CPU_GNT;
        else if (dma_ok_c) state_d = ST_DMA_GNT;
        else               state_d = ST_IDLE;
      end
      ST_CPU_GNT, ST_DMA_GNT: begin
        if (CYCLE_DONE) begin
          state_d = ST_TURN;
        end else if (expire_c) begin
          state_d   = ST_TURN;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so grants appear right after the sampling edge
  always_ff @(posedge nCLK or negedge CRESET_) begin
    if (!CRESET_) begin
      state       <= ST_IDLE;
      GNT_CPU     <= 1'b0;
      GNT_DMA     <= 1'b0;
      ARB_BUSY    <= 1'b0;
      ARB_TIMEOUT <= 1'b0;
    end else begin
      state       <= state_d;
      GNT_CPU     <= (state_d == ST_CPU_GNT);
      GNT_DMA     <= (state_d == ST_DMA_GNT);
      ARB_BUSY    <= (state_d != ST_IDLE);
      ARB_TIMEOUT <= timeout_d;
    end
  end

endmodule
